// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer.
package nibble_serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NIBBLES_MIN = 2;
  localparam int NIBBLES_MAX = 8;

  function automatic bit nibbles_ok(input int n);
    return (n >= NIBBLES_MIN) && (n <= NIBBLES_MAX);
  endfunction
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle between the register file side and the sequencer.
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (output start, op_sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, op_sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_add_ctrl_adder.sv
// 4-bit structural ripple-carry adder shared by the nibble sequencer.
module four_bit_ripple_str (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Runs one 4-bit ripple adder over NIBBLES slices, LSB first, carry held between slices.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  if (!nibbles_ok(NIBBLES)) begin : g_bad_nibbles
    $error("NIBBLES must be in 2..8");
  end

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry, busy_q, done_q, cout_q, ovf_q;
  logic [3:0]    nib_a, nib_b, nib_s;
  logic          nib_c;

  assign nib_a = a_q[{idx, 2'b00} +: 4];
  assign nib_b = b_q[{idx, 2'b00} +: 4];

  four_bit_ripple_str u_add (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry),
    .sum (nib_s),
    .cout(nib_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          // b is inverted and carry forced to 1 so subtraction reuses the adder.
          a_q    <= bus.a;
          b_q    <= bus.op_sub ? ~bus.b : bus.b;
          carry  <= bus.op_sub | bus.cin;
          idx    <= '0;
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          busy_q <= 1'b1;
          state  <= S_RUN;
        end
        S_RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= nib_s;
          carry <= nib_c;
          if (idx == LAST) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            cout_q <= nib_c;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (nib_s[3] != a_q[W-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench: arithmetic reference model compared every cycle, plus literal result checks.
module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();
  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: returns {cout, ovf, sum}.
  function automatic logic [W+1:0] model_calc(input logic [W-1:0] x, y, input logic c, s);
    longint ux, uy, sx, sy, ur, sr, lmax, lmin;
    logic co, ov;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lmax = (longint'(1) << (W - 1)) - 1;
    lmin = -(longint'(1) << (W - 1));
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + longint'(c);
      sr = sx + sy + longint'(c);
      co = (ur >= (longint'(1) << W));
    end
    ov = (sr > lmax) || (sr < lmin);
    return {co, ov, W'(ur)};
  endfunction

  logic         m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0] m_sum;
  logic [W+1:0] m_full;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cout <= 1'b0; m_ovf <= 1'b0;
      m_sum <= '0; m_full <= '0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_full <= model_calc(bus.a, bus.b, bus.cin, bus.op_sub);
        m_busy <= 1'b1; m_cnt <= 0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end
    end else if (m_cnt < NIBBLES) begin
      // After k serial steps the low k nibbles of the final result are visible.
      m_cnt <= m_cnt + 1;
      m_sum <= m_full[W-1:0] & W'((longint'(1) << (4 * (m_cnt + 1))) - 1);
      if (m_cnt + 1 == NIBBLES) begin
        m_done <= 1'b1; m_cout <= m_full[W+1]; m_ovf <= m_full[W];
      end
    end else begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("sum",  32'(bus.sum),  32'(m_sum));
    chk("cout", 32'(bus.cout), 32'(m_cout));
    chk("ovf",  32'(bus.ovf),  32'(m_ovf));
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20 && bus.done !== 1'b1) begin
      @(posedge clk); #2;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, y, input logic c, s, output int lat);
    @(posedge clk); #2;
    bus.a = x; bus.b = y; bus.cin = c; bus.op_sub = s; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic check_res(input string name, input int lat, input logic [W-1:0] es,
                           input logic ec, eo);
    chk({name, "_lat"},  32'(lat), 32'(NIBBLES));
    chk({name, "_sum"},  32'(bus.sum), 32'(es));
    chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({name, "_ovf"},  32'(bus.ovf), 32'(eo));
  endtask

  initial begin
    int lat, gap;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat); check_res("t1_add", lat, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat); check_res("t2_ripple", lat, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat); check_res("t3_sub", lat, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat); check_res("t4_addovf", lat, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat); check_res("t4_subovf", lat, 16'h7FFF, 1'b1, 1'b1);
    run_op(16'h0F0F, 16'h00F0, 1'b1, 1'b0, lat); check_res("t_cin", lat, 16'h1000, 1'b0, 1'b0);

    // Start pulse with new operands while RUN must be ignored.
    @(posedge clk); #2;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.op_sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    @(posedge clk); #2;
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.op_sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    chk("t5_busy_mid", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("t5_lat", 32'(lat), 32'd2);
    chk("t5_sum", 32'(bus.sum), 32'h3333);
    chk("t5_busy_done", 32'(bus.busy), 32'd1);
    @(posedge clk); #2;
    chk("t5_idle", 32'(bus.busy), 32'd0);

    // Start held high: back-to-back ops spaced NIBBLES+2 cycles apart.
    @(posedge clk); #2;
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0; bus.op_sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #2;
    wait_done(lat);
    chk("t_hold_sum1", 32'(bus.sum), 32'h0100);
    @(posedge clk); #2;
    wait_done(gap);
    bus.start = 1'b0;
    chk("t_hold_gap", 32'(gap + 1), 32'(NIBBLES + 2));
    chk("t_hold_sum2", 32'(bus.sum), 32'h0100);
    repeat (2) @(posedge clk);

    // Reset mid-operation clears everything immediately.
    @(posedge clk); #2;
    bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    chk("t6_sum",  32'(bus.sum),  32'd0);
    chk("t6_cout", 32'(bus.cout), 32'd0);
    chk("t6_ovf",  32'(bus.ovf),  32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat); check_res("t6_after", lat, 16'h2345, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
